// File: rtl/comb_decim.sv
`default_nettype none
// ============================================================================
// Module   : comb_decim
// Brief    : Decimate-by-R front end followed by N registered CIC comb stages.
// Revision : 1.0 - initial release
// ============================================================================
module comb_decim #(
    parameter int  Win  = 16,
    parameter int  Wg   = 22,
    parameter int  R    = 8,
    parameter int  N    = 3,
    parameter int  Wout = 16,
    localparam int W    = Wg + Win,
    localparam int CW   = (R > 1) ? $clog2(R) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [W-1:0]    data_in,
    input  logic                   val_in,
    output logic signed [W-1:0]    data_full,
    output logic signed [Wout-1:0] data_out,
    output logic                   val_out
);

    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                accept_d;

    logic signed [W-1:0] stage_q [N];
    logic signed [W-1:0] prev_q  [N];
    logic [N-1:0]        vld_q;

    logic signed [W-1:0] in_d    [N];
    logic [N-1:0]        in_v_d;
    logic signed [W-1:0] diff_d  [N];

    always_comb begin
        accept_d = val_in && (cnt_q == CW'(R - 1));
        cnt_d    = cnt_q;
        if (val_in) begin
            cnt_d = accept_d ? '0 : cnt_q + CW'(1);
        end
    end

    // Stage 0 is fed by the decimated input; later stages by the stage before.
    always_comb begin
        in_d[0]   = data_in;
        in_v_d[0] = accept_d;
        for (int k = 1; k < N; k++) begin
            in_d[k]   = stage_q[k-1];
            in_v_d[k] = vld_q[k-1];
        end
        for (int k = 0; k < N; k++) begin
            diff_d[k] = in_d[k] - prev_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            vld_q <= '0;
            for (int k = 0; k < N; k++) begin
                stage_q[k] <= '0;
                prev_q[k]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            vld_q <= in_v_d;
            for (int k = 0; k < N; k++) begin
                if (in_v_d[k]) begin
                    prev_q[k]  <= in_d[k];
                    stage_q[k] <= diff_d[k];
                end
            end
        end
    end

    assign data_full = stage_q[N-1];
    assign data_out  = stage_q[N-1][W-1 -: Wout];
    assign val_out   = vld_q[N-1];

endmodule
`default_nettype wire

// File: tb/tb_comb_decim.sv
`default_nettype none
// ============================================================================
// Module   : tb_comb_decim
// Brief    : Self-checking bench for comb_decim against an N-th difference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comb_decim;

    localparam int W    = 38;
    localparam int WOUT = 16;
    localparam int R    = 8;
    localparam int N    = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   val_in;
    logic signed [W-1:0]    data_in;
    logic signed [W-1:0]    data_full;
    logic signed [WOUT-1:0] data_out;
    logic                   val_out;

    comb_decim #(.Win(16), .Wg(22), .R(R), .N(N), .Wout(WOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .val_in    (val_in),
        .data_full (data_full),
        .data_out  (data_out),
        .val_out   (val_out)
    );

    always #5 clk = ~clk;

    int              edge_cnt = 0;
    logic            smp_v    = 1'b0;
    logic            smp_rst  = 1'b1;
    logic [W-1:0]    smp_d    = '0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        smp_v    <= val_in;
        smp_d    <= data_in;
        smp_rst  <= rst;
    end

    int           checks = 0;
    int           errors = 0;
    int           nvalid;
    longint       hist[$];
    longint       pend_y[$];
    int           pend_e[$];
    logic [W-1:0] last;
    longint       caps[$];
    longint       capo[$];
    int           cap_edge[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output j is the N-th backward difference of the decimated sequence,
    // with samples before the first one taken as zero.
    function automatic longint nth_diff();
        longint y = 0;
        longint c = 1;
        int     l = hist.size();
        for (int i = 0; i <= N; i++) begin
            if (l - 1 - i >= 0) y += ((i % 2) != 0 ? -c : c) * hist[l-1-i];
            c = c * (N - i) / (i + 1);
        end
        return y;
    endfunction

    task automatic compare_loop();
        logic   expv;
        longint y;
        forever begin
            @(negedge clk);
            if (rst) begin
                nvalid = 0;
                hist.delete();
                pend_y.delete();
                pend_e.delete();
                last = '0;
                chk("rst_val_out", 64'(val_out), 64'(0));
                chk("rst_data_full", 64'($unsigned(data_full)), 64'(0));
                chk("rst_data_out", 64'($unsigned(data_out)), 64'(0));
            end else begin
                if (!smp_rst && smp_v) begin
                    nvalid++;
                    if (nvalid % R == 0) begin
                        hist.push_back(longint'($signed(smp_d)));
                        while (hist.size() > N + 1) void'(hist.pop_front());
                        y = nth_diff();
                        pend_y.push_back(y);
                        pend_e.push_back(edge_cnt + N - 1);
                    end
                end
                expv = (pend_e.size() > 0) && (pend_e[0] == edge_cnt);
                if (expv) begin
                    last = W'(pend_y[0]);
                    void'(pend_y.pop_front());
                    void'(pend_e.pop_front());
                end
                chk("val_out", 64'(val_out), 64'(expv));
                chk("data_full", 64'($unsigned(data_full)), 64'(last));
                chk("data_out", 64'($unsigned(data_out)), 64'(last[W-1 -: WOUT]));
                if (val_out) begin
                    caps.push_back(longint'(data_full));
                    capo.push_back(longint'(data_out));
                    cap_edge.push_back(edge_cnt);
                end
            end
        end
    endtask

    task automatic step(input logic v, input longint d);
        @(posedge clk);
        #2;
        val_in  = v;
        data_in = W'(d);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst    = 1'b1;
        val_in = 1'b0;
        @(posedge clk);
        #2;
        rst    = 1'b0;
    endtask

    int m;
    int e0;

    initial begin
        rst     = 1'b1;
        val_in  = 1'b0;
        data_in = '0;
        fork
            compare_loop();
        join_none
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Zero input at full rate
        m = caps.size();
        repeat (64) step(1'b1, 0);
        repeat (5) step(1'b0, 0);
        chk("zero_pulses", 64'(caps.size() - m), 64'(8));
        if (caps.size() - m >= 2) chk("zero_spacing", 64'(cap_edge[m+1] - cap_edge[m]), 64'(8));
        if (caps.size() - m >= 8) chk("zero_last", caps[m+7], 64'(0));

        // Ramp at full rate, also pins first-output latency
        do_reset();
        m = caps.size();
        step(1'b1, 0);
        e0 = edge_cnt;
        for (int k = 1; k < 40; k++) step(1'b1, 100 * k);
        repeat (5) step(1'b0, 0);
        if (caps.size() - m >= 4) begin
            chk("latency", 64'(cap_edge[m] - e0), 64'(10));
            chk("ramp0", caps[m],   64'(700));
            chk("ramp1", caps[m+1], -64'sd600);
            chk("ramp2", caps[m+2], -64'sd100);
            chk("ramp3", caps[m+3], 64'(0));
        end else begin
            chk("ramp_pulses", 64'(caps.size() - m), 64'(5));
        end

        // Ramp with val_in alternating 1/0
        do_reset();
        m = caps.size();
        for (int k = 0; k < 32; k++) begin
            step(1'b1, 100 * k);
            step(1'b0, 0);
        end
        repeat (5) step(1'b0, 0);
        if (caps.size() - m >= 4) begin
            chk("gap_spacing", 64'(cap_edge[m+1] - cap_edge[m]), 64'(16));
            chk("gap0", caps[m],   64'(700));
            chk("gap1", caps[m+1], -64'sd600);
            chk("gap2", caps[m+2], -64'sd100);
            chk("gap3", caps[m+3], 64'(0));
        end else begin
            chk("gap_pulses", 64'(caps.size() - m), 64'(4));
        end

        // Wraparound: 2^37-100 followed by -2^37+100
        do_reset();
        m = caps.size();
        repeat (8) step(1'b1, (64'sd1 <<< 37) - 100);
        repeat (8) step(1'b1, -(64'sd1 <<< 37) + 100);
        repeat (5) step(1'b0, 0);
        if (caps.size() - m >= 2) begin
            chk("wrap0", caps[m], (64'sd1 <<< 37) - 100);
            chk("wrap0_dout", capo[m], 64'(32767));
            chk("wrap1", caps[m+1], 64'(400));
            chk("wrap1_dout", capo[m+1], 64'(0));
        end else begin
            chk("wrap_pulses", 64'(caps.size() - m), 64'(2));
        end

        // Reset mid-operation
        do_reset();
        m = caps.size();
        repeat (5) step(1'b1, 5);
        do_reset();
        repeat (7) step(1'b1, 5);
        repeat (5) step(1'b0, 0);
        chk("midrst_none1", 64'(caps.size() - m), 64'(0));
        step(1'b1, 5);
        do_reset();
        repeat (5) step(1'b0, 0);
        chk("midrst_none2", 64'(caps.size() - m), 64'(0));
        repeat (8) step(1'b1, 5);
        repeat (5) step(1'b0, 0);
        chk("midrst_one", 64'(caps.size() - m), 64'(1));
        if (caps.size() - m >= 1) chk("midrst_val", caps[m], 64'(5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comb_decim.md
COMB_DECIM -- requirements
Module: comb_decim

Interface
REQ-001 SHALL have parameter Win, default 16: input sample width of the filter chain.
REQ-002 SHALL have parameter Wg, default 22: word growth; internal width W = Wg+Win = 38.
REQ-003 SHALL have parameter R, default 8: decimation factor, legal range 2..256.
REQ-004 SHALL have parameter N, default 3: number of comb stages, legal range 1..8.
REQ-005 SHALL have parameter Wout, default 16: output width, Wout <= W.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port data_in, input, W signed: integrator-chain output sample.
REQ-009 SHALL have port val_in, input, 1: data_in valid this cycle.
REQ-010 SHALL have port data_full, output, W signed: full-precision comb output.
REQ-011 SHALL have port data_out, output, Wout signed: truncated output.
REQ-012 SHALL have port val_out, output, 1: single-cycle pulse, data_full/data_out valid.

Function
REQ-013 SHALL keep a decimation counter cnt, 0..R-1, advanced by 1 only on edges with val_in=1, wrapping R-1 -> 0; no advance when val_in=0.
REQ-014 SHALL accept a sample as decimated only on an edge with val_in=1 and cnt=R-1, i.e. the R-th, 2R-th, ... valid input after reset.
REQ-015 SHALL implement N cascaded comb stages, each y = x - x_prev, differential delay 1; x_prev per stage updates only when that stage receives a valid sample.
REQ-016 SHALL register every stage; each stage carries its own valid bit, shifted one stage per clock.
REQ-017 SHALL give latency N edges: sample accepted on edge t, val_out high from edge t+N-1 to edge t+N, exactly one cycle per decimated sample.
REQ-018 SHALL perform all arithmetic modulo 2^W (two's-complement wrap, no saturation); wrap in data_in SHALL produce the correct difference.
REQ-019 SHALL drive data_out = data_full[W-1 : W-Wout] (MSB truncation, no rounding).
REQ-020 SHALL hold data_full and data_out unchanged between val_out pulses.
REQ-021 SHALL process independently of val_in gaps: a decimated sample in the pipeline SHALL complete even if val_in falls.
REQ-022 SHALL not require val_in deasserted between samples; val_in=1 every cycle is legal (max rate).

Reset
REQ-023 SHALL on rst=1 asynchronously clear cnt, all stage registers, all x_prev registers, all valid bits, data_full=0, data_out=0, val_out=0.
REQ-024 SHALL discard any in-flight sample when rst asserts mid-operation; no val_out until R new valid inputs after rst deasserts.
REQ-025 SHALL ignore val_in while rst=1.

Verification
REQ-026 SHALL verify zero input: rst, then 64 cycles val_in=1, data_in=0 -> 8 val_out pulses, spaced 8 cycles, data_full=0.
REQ-027 SHALL verify ramp (R=8,N=3): data_in=100*k on k-th valid input (k=0..) -> data_full = 700, -600, -100, 0, 0...
REQ-028 SHALL verify latency: val_in=1 continuous from reset -> first val_out high in the cycle after edge 8+N-1=10 (counting edges from the first with val_in=1 as edge 1).
REQ-029 SHALL verify gaps: val_in alternating 1/0 -> val_out every 16 cycles, same data_full sequence as REQ-027.
REQ-030 SHALL verify wrap: decimated inputs 2^37-100, then -2^37+100 (wrapped) -> stage-1 difference 200, no overflow artefact.
REQ-031 SHALL verify reset mid-operation: rst pulse after 5 valid inputs and again 1 cycle after an accepted sample -> no val_out until 8 new valid inputs, outputs 0 meanwhile.
